// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the alu_mdu execute unit.
package alu_pkg;

  localparam int FN_ADD  = 0;
  localparam int FN_SUB  = 1;
  localparam int FN_AND  = 2;
  localparam int FN_OR   = 3;
  localparam int FN_XOR  = 4;
  localparam int FN_NOR  = 5;
  localparam int FN_SLT  = 6;
  localparam int FN_SLL  = 7;
  localparam int FN_SRL  = 8;
  localparam int FN_SRA  = 9;
  localparam int FN_MULU = 10;
  localparam int FN_DIVU = 11;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;

  typedef struct packed {
    logic zf;
    logic of;
    logic cf;
    logic sf;
  } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-bit core for the single-cycle ops plus their flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 4
) (
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  res,
  output flags_t            flags
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;

  assign shamt = b[SH_W-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    flags = '0;
    case (func)
      FUNC_W'(FN_ADD): begin
        res      = sum[WIDTH-1:0];
        flags.cf = sum[WIDTH];
        flags.of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FUNC_W'(FN_SUB): begin
        res      = diff[WIDTH-1:0];
        flags.cf = diff[WIDTH];
        flags.of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      FUNC_W'(FN_AND): res = a & b;
      FUNC_W'(FN_OR):  res = a | b;
      FUNC_W'(FN_XOR): res = a ^ b;
      FUNC_W'(FN_NOR): res = ~(a | b);
      FUNC_W'(FN_SLT): res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      FUNC_W'(FN_SLL): res = a << shamt;
      FUNC_W'(FN_SRL): res = a >> shamt;
      FUNC_W'(FN_SRA): res = WIDTH'($signed(a) >>> shamt);
      // MULU/DIVU are handled by the sequencer; illegal codes fall through to 0
      default:         res = '0;
    endcase
    flags.zf = (res == '0);
    flags.sf = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative shift-add multiply and restoring divide.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  res,
  output logic [WIDTH-1:0]  res_hi,
  output logic              zf,
  output logic              of,
  output logic              cf,
  output logic              sf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     res_q, res_d, res_hi_q, res_hi_d;
  flags_t               flg_q, flg_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     c_res;
  flags_t               c_flg;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, it_nxt;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;

  alu_comb #(.WIDTH(WIDTH), .FUNC_W(FUNC_W)) u_comb (
    .func  (func),
    .a     (a),
    .b     (b),
    .res   (c_res),
    .flags (c_flg)
  );

  // MUL: acc = {partial hi, remaining multiplier bits}; add multiplicand then shift right
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // DIV: acc = {remainder, dividend/quotient}; shift left, subtract divisor if it fits
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_nxt = (rem_sh >= {1'b0, opnd_q}) ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                              : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign it_nxt  = (state_q == MUL) ? mul_nxt : div_nxt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    flg_d    = flg_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, EXEC: begin
        state_d = IDLE;
        if (start) begin
          if (func == FUNC_W'(FN_MULU)) begin
            state_d = MUL;
            acc_d   = {{WIDTH{1'b0}}, b};
            opnd_d  = a;
            cnt_d   = '0;
          end else if (func == FUNC_W'(FN_DIVU) && b != '0) begin
            state_d = DIV;
            acc_d   = {{WIDTH{1'b0}}, a};
            opnd_d  = b;
            cnt_d   = '0;
          end else if (func == FUNC_W'(FN_DIVU)) begin
            state_d  = EXEC;
            done_d   = 1'b1;
            res_d    = '1;
            res_hi_d = a;
            flg_d    = '{zf: 1'b0, of: 1'b0, cf: 1'b0, sf: 1'b1};
          end else begin
            state_d  = EXEC;
            done_d   = 1'b1;
            res_d    = c_res;
            res_hi_d = '0;
            flg_d    = c_flg;
          end
        end
      end
      MUL, DIV: begin
        acc_d = it_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
          res_d    = it_nxt[WIDTH-1:0];
          res_hi_d = it_nxt[2*WIDTH-1:WIDTH];
          flg_d.zf = (it_nxt[WIDTH-1:0] == '0);
          flg_d.sf = it_nxt[WIDTH-1];
          flg_d.of = (state_q == MUL) && (it_nxt[2*WIDTH-1:WIDTH] != '0);
          flg_d.cf = flg_d.of;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      flg_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flg_q    <= flg_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE) || (state_q == EXEC);
  assign done   = done_q;
  assign res    = res_q;
  assign res_hi = res_hi_q;
  assign zf     = flg_q.zf;
  assign of     = flg_q.of;
  assign cf     = flg_q.cf;
  assign sf     = flg_q.sf;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, sequential successor to the 8-bit combinational ALU: WIDTH-bit datapath plus an iterative unsigned multiply/divide unit.
- Same flag set (zf, of, cf, sf), with registered outputs and a start/ready/done handshake.
- Sits in the execute stage. Single-cycle ops complete in 1 cycle; MULU/DIVU take WIDTH iterations.

Parameters:
- WIDTH, 8, datapath width in bits (>=4, power of 2).
- FUNC_W, 4, width of the func opcode.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- func  in  FUNC_W  opcode, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- ready  out  1  block idle, can accept start
- done  out  1  one-cycle pulse; results valid
- res  out  WIDTH  primary result (low product / quotient)
- res_hi  out  WIDTH  high product / remainder; 0 for other ops
- zf  out  1  res == 0
- of  out  1  signed overflow (see rules)
- cf  out  1  carry/borrow (see rules)
- sf  out  1  res[WIDTH-1]

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1, done=0.
  - res, res_hi, zf, of, cf, sf = 0.
  - Any op in flight is abandoned; no done is produced for it.
- Func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed; res = 1/0)
  - 7 SLL, 8 SRL, 9 SRA (shift amount = b[$clog2(WIDTH)-1:0])
  - 10 MULU, 11 DIVU
  - 12-15 illegal: res=0, zf=1, other flags 0, single-cycle.
- Flags:
  - ADD: cf = carry out; of = (a,b same sign) and res sign differs.
  - SUB: cf = borrow (a<b unsigned); of = (a,b differ in sign) and res sign != a sign.
  - MULU: of = cf = (res_hi != 0).
  - DIVU, logic, shift, SLT: of = cf = 0.
  - zf and sf always follow the final res.
- States: IDLE -> (start & ready) -> EXEC (single-cycle ops) | MUL | DIV.
  - EXEC -> IDLE after 1 cycle.
  - MUL/DIV -> IDLE when the iteration counter reaches WIDTH.
- Latency (start sampled on edge E0):
  - Single-cycle ops: outputs registered on E0; done=1 for the cycle after E0.
  - MULU: shift-add, one bit per edge on E1..E_WIDTH; done=1 for the cycle after E_WIDTH.
  - DIVU: restoring divide, one bit per edge, same timing as MULU.
- ready:
  - Low from after E0 until the done cycle.
  - High during the done cycle, so back-to-back starts are allowed.
  - Single-cycle ops never drop ready.
- start while ready=0: ignored, no side effects. Operands are internally latched, so a/b/func may change freely after E0.
- DIVU with b=0: no iteration; behaves as a single-cycle op with res = all ones, res_hi = a, of = cf = 0.
- Outputs hold their last value between done pulses.
- Counter width: $clog2(WIDTH)+1; the counter wraps to 0 on completion.

Decomposition:
- Shared package alu_pkg:
  - func code localparams (FN_ADD..FN_DIVU)
  - state enum (IDLE, EXEC, MUL, DIV)
  - flag bundle typedef
- Sub-module alu_comb: purely combinational WIDTH-bit core for ops 0-9 plus flag generation.
- alu_mdu holds the FSM, the mul/div datapath (accumulator, shift registers) and the output registers.

Test Plan (WIDTH=8):
- ADD a=5, b=5 -> done 1 cycle later; res=10, zf=of=cf=sf=0, ready stays 1. SUB a=5, b=5 -> res=0, zf=1, cf=0.
- ADD a=127, b=1 -> res=128, of=1, sf=1, cf=0. SUB a=3, b=5 -> res=0xFE, cf=1, sf=1, of=0.
- MULU a=200, b=3 -> ready low for 8 cycles; done after E8 with res=0x58, res_hi=0x02, of=cf=1. Back-to-back ADD issued in the done cycle completes 1 cycle later.
- DIVU a=200, b=7 -> res=28, res_hi=4, done after E8. DIVU a=9, b=0 -> res=0xFF, res_hi=9, done 1 cycle later.
- Start MULU; pulse start with ADD at cycle 3 -> ignored, MULU result unchanged. Assert rst at cycle 4 -> immediately ready=1 and all outputs 0; no done follows.
- SRA a=0x80, b=3 -> res=0xF0, sf=1. SLT a=0xFF (-1), b=1 -> res=1. func=13 -> res=0, zf=1.
